// File: rtl/bp_sched.sv
// Belief-propagation polar decoder scheduler: walks R/L passes over butterfly stages and tags cell writes.
// Optional BP_EARLY_STOP_EN: when defined, converged=1 in CHECK ends the decode early.
module bp_sched #(
   parameter int unsigned LOG_N    = 8,
   parameter int unsigned LOG_P    = 3,
   parameter int unsigned CELL_LAT = 2,
   parameter int unsigned MAX_ITER = 40,
   localparam int unsigned GW = ((LOG_N - 1 - LOG_P) < 1) ? 1 : (LOG_N - 1 - LOG_P),
   localparam int unsigned SW = ($clog2(LOG_N) < 1) ? 1 : $clog2(LOG_N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          hold,
   input  logic          converged,
   output logic          busy,
   output logic          done,
   output logic          cell_en,
   output logic          rd_en,
   output logic          rd_dir,
   output logic [SW-1:0] rd_stage,
   output logic [GW-1:0] rd_group,
   output logic          wr_en,
   output logic          wr_dir,
   output logic [SW-1:0] wr_stage,
   output logic [GW-1:0] wr_group,
   output logic [7:0]    iter_cnt
);

   localparam int unsigned G  = 1 << GW;
   localparam int unsigned BW = 3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RPASS = 3'd1;
   localparam logic [2:0] S_LPASS = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [GW-1:0] group_q, group_d;
   logic [BW-1:0] bub_q, bub_d;
   logic          in_bub_q, in_bub_d;
   logic [7:0]    iter_q, iter_d;
   logic [7:0]    iter_inc;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rd_en_q, rd_en_d;
   logic          rd_dir_q, rd_dir_d;
   logic          early_stop;

`ifdef BP_EARLY_STOP_EN
   assign early_stop = converged;
`else
   logic unused_converged;
   assign unused_converged = converged;
   assign early_stop       = 1'b0;
`endif

   assign iter_inc = iter_q + 8'd1;

   // State and counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         stage_q  <= '0;
         group_q  <= '0;
         bub_q    <= '0;
         in_bub_q <= 1'b0;
         iter_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_dir_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         group_q  <= group_d;
         bub_q    <= bub_d;
         in_bub_q <= in_bub_d;
         iter_q   <= iter_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rd_en_q  <= rd_en_d;
         rd_dir_q <= rd_dir_d;
      end
   end

   // Next-state: each stage is G issue cycles followed by CELL_LAT bubbles
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      group_d  = group_q;
      bub_d    = bub_q;
      in_bub_d = in_bub_q;
      iter_d   = iter_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RPASS;
               stage_d  = '0;
               group_d  = '0;
               bub_d    = '0;
               in_bub_d = 1'b0;
               iter_d   = '0;
            end
         end
         S_RPASS, S_LPASS: begin
            if (!hold) begin
               if (!in_bub_q) begin
                  if (group_q == GW'(G - 1)) begin
                     in_bub_d = 1'b1;
                     bub_d    = '0;
                  end else begin
                     group_d = group_q + GW'(1);
                  end
               end else if (bub_q == BW'(CELL_LAT - 1)) begin
                  in_bub_d = 1'b0;
                  bub_d    = '0;
                  group_d  = '0;
                  if (state_q == S_RPASS) begin
                     if (stage_q == SW'(LOG_N - 1)) state_d = S_LPASS;
                     else                           stage_d = stage_q + SW'(1);
                  end else begin
                     if (stage_q == '0) state_d = S_CHECK;
                     else               stage_d = stage_q - SW'(1);
                  end
               end else begin
                  bub_d = bub_q + BW'(1);
               end
            end
         end
         S_CHECK: begin
            if (!hold) begin
               iter_d  = iter_inc;
               stage_d = '0;
               group_d = '0;
               if ((iter_inc == 8'(MAX_ITER)) || early_stop) state_d = S_DONE;
               else                                          state_d = S_RPASS;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d   = (state_d == S_RPASS) || (state_d == S_LPASS) || (state_d == S_CHECK);
      done_d   = (state_d == S_DONE);
      rd_en_d  = ((state_d == S_RPASS) || (state_d == S_LPASS)) && !in_bub_d;
      rd_dir_d = (state_d == S_LPASS);
   end

   // Write-tag delay line mirrors the cell pipeline, so it only moves when cells do
   logic          dl_en    [CELL_LAT];
   logic          dl_dir   [CELL_LAT];
   logic [SW-1:0] dl_stage [CELL_LAT];
   logic [GW-1:0] dl_group [CELL_LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(CELL_LAT); i++) begin
            dl_en[i]    <= 1'b0;
            dl_dir[i]   <= 1'b0;
            dl_stage[i] <= '0;
            dl_group[i] <= '0;
         end
      end else if (cell_en) begin
         dl_en[0]    <= rd_en_q;
         dl_dir[0]   <= rd_dir_q;
         dl_stage[0] <= stage_q;
         dl_group[0] <= group_q;
         for (int i = 1; i < int'(CELL_LAT); i++) begin
            dl_en[i]    <= dl_en[i-1];
            dl_dir[i]   <= dl_dir[i-1];
            dl_stage[i] <= dl_stage[i-1];
            dl_group[i] <= dl_group[i-1];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign cell_en  = busy_q & ~hold;
   assign rd_en    = rd_en_q & ~hold;
   assign rd_dir   = rd_dir_q;
   assign rd_stage = stage_q;
   assign rd_group = group_q;
   assign wr_en    = dl_en[CELL_LAT-1] & ~hold;
   assign wr_dir   = dl_dir[CELL_LAT-1];
   assign wr_stage = dl_stage[CELL_LAT-1];
   assign wr_group = dl_group[CELL_LAT-1];
   assign iter_cnt = iter_q;

endmodule

// File: tb/tb_bp_sched.sv
// Directed bench for bp_sched in the small configuration (LOG_N=3, LOG_P=1, CELL_LAT=2, MAX_ITER=2).
module tb_bp_sched;

   localparam int NC = 60;

   logic       clk = 1'b0;
   logic       rst_n, start, hold, converged;
   logic       busy, done, cell_en, rd_en, rd_dir, wr_en, wr_dir;
   logic [1:0] rd_stage, wr_stage;
   logic [0:0] rd_group, wr_group;
   logic [7:0] iter_cnt;

   int checks = 0;
   int errors = 0;

   // Per-cycle packed view: {0, busy, done, cell_en, rd_en, rd_dir, wr_en, wr_dir,
   //                         rd_stage4, rd_group4, wr_stage4, wr_group4, iter_cnt}
   logic [31:0] obs  [NC];
   logic [31:0] expv [NC];
   logic [31:0] msk  [NC];

   always #5 clk = ~clk;

   bp_sched #(.LOG_N(3), .LOG_P(1), .CELL_LAT(2), .MAX_ITER(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .converged(converged),
      .busy(busy), .done(done), .cell_en(cell_en),
      .rd_en(rd_en), .rd_dir(rd_dir), .rd_stage(rd_stage), .rd_group(rd_group),
      .wr_en(wr_en), .wr_dir(wr_dir), .wr_stage(wr_stage), .wr_group(wr_group),
      .iter_cnt(iter_cnt)
   );

   // Reference schedule for an unstalled timeline: stage slots of 4 cycles, CHECK every 25th cycle
   function automatic void sched(input int e, input int n, output logic b, output logic en,
                                 output logic dir, output int stg, output int grp, output int it);
      int t, j;
      b   = (e >= 1) && (e <= 25 * n);
      en  = 1'b0;
      dir = 1'b0;
      stg = 0;
      grp = 0;
      it  = (e > 25 * n) ? n : 0;
      if (b) begin
         t  = (e - 1) % 25;
         it = (e - 1) / 25;
         if (t < 24) begin
            j   = t / 4;
            en  = (t % 4) < 2;
            grp = t % 4;
            dir = (j >= 3);
            stg = (j < 3) ? j : 5 - j;
         end
      end
   endfunction

   task automatic build_exp(input int hf, input int ht, input int n, input int rst_at);
      logic held, b, en, dir, b2, en2, dir2, rd, wr, dn;
      int   e, stg, grp, it, stg2, grp2, it2;
      for (int k = 0; k < NC; k++) begin
         if (rst_at >= 0 && k > rst_at) begin
            expv[k] = '0;
            msk[k]  = '1;
            continue;
         end
         held = (k >= hf) && (k <= ht);
         e    = (hf < 0 || k < hf) ? k : (held ? hf : k - (ht - hf + 1));
         sched(e, n, b, en, dir, stg, grp, it);
         sched(e - 2, n, b2, en2, dir2, stg2, grp2, it2);
         dn = (e == 25 * n + 1);
         rd = en & ~held;
         wr = en2 & ~held;
         expv[k] = {1'b0, b, dn, b & ~held, rd, dir, wr, dir2,
                    4'(stg), 4'(grp), 4'(stg2), 4'(grp2), 8'(it)};
         msk[k]  = {1'b0, 6'h3f, wr, {8{rd}}, {8{wr}}, {8{(k > 0) && (e >= 1)}}};
      end
   endtask

   // Start a decode in cycle 0 and record NC cycles of outputs
   task automatic record(input int hf, input int ht, input int conv_at, input int rst_at,
                         input int xs1, input int xs2, input logic idle_hold);
      start     = 1'b1;
      hold      = idle_hold || (hf == 0);
      converged = (conv_at == 0);
      rst_n     = (rst_at != 0);
      for (int k = 0; k < NC; k++) begin
         @(negedge clk);
         obs[k] = {1'b0, busy, done, cell_en, rd_en, rd_dir, wr_en, wr_dir,
                   4'(rd_stage), 4'(rd_group), 4'(wr_stage), 4'(wr_group), iter_cnt};
         @(posedge clk);
         #1;
         start     = (k + 1 == xs1) || (k + 1 == xs2);
         hold      = (k + 1 >= hf) && (k + 1 <= ht);
         converged = (k + 1 == conv_at);
         rst_n     = (k + 1 != rst_at);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; hold = 1'b1; converged = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b expected 0", done); end
      checks++; if (cell_en !== 1'b0)  begin errors++; $display("FAIL reset cell_en: got %b expected 0", cell_en); end
      checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset rd_en: got %b expected 0", rd_en); end
      checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset wr_en: got %b expected 0", wr_en); end
      checks++; if (rd_dir !== 1'b0)   begin errors++; $display("FAIL reset rd_dir: got %b expected 0", rd_dir); end
      checks++; if (rd_stage !== 2'd0) begin errors++; $display("FAIL reset rd_stage: got %0d expected 0", rd_stage); end
      checks++; if (rd_group !== 1'd0) begin errors++; $display("FAIL reset rd_group: got %0d expected 0", rd_group); end
      checks++; if (wr_stage !== 2'd0) begin errors++; $display("FAIL reset wr_stage: got %0d expected 0", wr_stage); end
      checks++; if (iter_cnt !== 8'd0) begin errors++; $display("FAIL reset iter_cnt: got %0d expected 0", iter_cnt); end
      @(posedge clk);
      #1;
      rst_n = 1'b1; start = 1'b0; hold = 1'b0; converged = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      record(-1, -1, -1, -1, -1, -1, 1'b0);
      build_exp(-1, -1, 2, -1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL basic cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      checks++;
      if (iter_cnt !== 8'd2) begin
         errors++;
         $display("FAIL idle_iter_cnt: got %0d expected 2", iter_cnt);
      end
      @(posedge clk);
      #1;
      record(-1, -1, -1, -1, -1, -1, 1'b0);
      build_exp(-1, -1, 2, -1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   task automatic test_stall();
      record(6, 8, -1, -1, -1, -1, 1'b0);
      build_exp(6, 8, 2, -1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL stall cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   task automatic test_early_stop();
      int n;
`ifdef BP_EARLY_STOP_EN
      n = 1;
`else
      n = 2;
`endif
      record(-1, -1, 25, -1, -1, -1, 1'b0);
      build_exp(-1, -1, n, -1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL early_stop cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   task automatic test_ignored_start();
      record(-1, -1, -1, -1, 5, 25, 1'b1);
      build_exp(-1, -1, 2, -1);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL ignored_start cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   task automatic test_reset_abort();
      record(-1, -1, -1, 10, -1, -1, 1'b0);
      build_exp(-1, -1, 2, 10);
      for (int k = 0; k < NC; k++) begin
         checks++;
         if ((obs[k] & msk[k]) !== (expv[k] & msk[k])) begin
            errors++;
            $display("FAIL reset_abort cycle %0d: got %h expected %h mask %h", k, obs[k], expv[k], msk[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_early_stop();
      test_ignored_start();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_sched.md
BP_SCHED -- requirements
Module: bp_sched

Interface
REQ-001 Parameter LOG_N, default 8: log2 of code length N; the decoder has LOG_N butterfly stages.
REQ-002 Parameter LOG_P, default 3: log2 of the number of parallel bp_2_cell instances P; legal range 0 <= LOG_P < LOG_N-1.
REQ-003 Parameter CELL_LAT, default 2: butterfly cell en-gated latency; legal range 1..7.
REQ-004 Parameter MAX_ITER, default 40: maximum number of BP iterations; legal range 1..255.
REQ-005 Derived widths: GW = LOG_N-1-LOG_P (minimum 1 bit); G = 2^GW groups per stage; SW = clog2(LOG_N) (minimum 1 bit).
REQ-006 clk  in  1: single clock; all logic on the rising edge.
REQ-007 rst_n  in  1: reset, synchronous and active-low.
REQ-008 start  in  1: request one decode; honoured only in IDLE.
REQ-009 hold  in  1: downstream stall; freezes all scheduling state while high.
REQ-010 converged  in  1: hard-decision convergence flag, valid in CHECK.
REQ-011 busy  out  1: high from the cycle after start is accepted through the last CHECK.
REQ-012 done  out  1: one-cycle completion pulse.
REQ-013 cell_en  out  1: enable to all cells; equals busy & ~hold.
REQ-014 rd_en, rd_dir, rd_stage[SW], rd_group[GW]  out: issue strobe, direction (0 = R pass, 1 = L pass), stage and group being read.
REQ-015 wr_en, wr_dir, wr_stage[SW], wr_group[GW]  out: write-back strobe and tags.
REQ-016 iter_cnt  out  8: number of completed iterations.

Function
REQ-017 FSM states: IDLE, RPASS, LPASS, CHECK, DONE.
REQ-018 IDLE with start=1 -> RPASS at rd_stage=0, rd_group=0; iter_cnt cleared.
REQ-019 Each stage lasts G+CELL_LAT cycles:
- group cycles: rd_en=1, rd_group counts 0..G-1;
- then CELL_LAT bubble cycles with rd_en=0.
REQ-020 RPASS walks stages 0 up to LOG_N-1, then enters LPASS.
REQ-021 LPASS walks stages LOG_N-1 down to 0, then enters CHECK; rd_dir=1 in LPASS, 0 otherwise.
REQ-022 One iteration takes 2*LOG_N*(G+CELL_LAT) cycles; CHECK takes one cycle and increments iter_cnt.
REQ-023 CHECK -> DONE if the incremented iter_cnt = MAX_ITER, or on early stop (REQ-033); otherwise -> RPASS at stage 0.
REQ-024 DONE asserts done=1 with busy=0 for one cycle, then -> IDLE.
REQ-025 The wr_* outputs are the rd_* values delayed through a CELL_LAT-deep shift register that advances only when cell_en=1; wr_en is additionally gated by ~hold.
REQ-026 hold=1 freezes the FSM, counters and delay line; rd_en=0 and wr_en=0 while held; on release, issue resumes exactly where it stopped.
REQ-027 The bubble cycles guarantee that the last write of a stage completes before the first read of the next stage.
REQ-028 start is ignored in every state except IDLE; hold in IDLE has no effect.

Reset
REQ-029 rst_n=0 at a clock edge forces IDLE on that edge.
REQ-030 Every output, counter and delay-line stage resets to 0.
REQ-031 Reset mid-decode aborts the decode with no done pulse.
REQ-032 rst_n=0 takes priority over start and hold.

Configuration
REQ-033 Macro BP_EARLY_STOP_EN defined: in CHECK, converged=1 -> DONE regardless of iter_cnt.
REQ-034 Macro BP_EARLY_STOP_EN undefined: the converged port exists but is ignored; every decode runs MAX_ITER iterations.

Verification
REQ-035 Base configuration for all scenarios: LOG_N=3, LOG_P=1, CELL_LAT=2, MAX_ITER=2, so G=2, stages are 4 cycles and an iteration is 24 cycles.
REQ-036 Basic decode: start at cycle 0 -> rd_en high in cycles 1,2,5,6,...; CHECK at cycles 25 and 50; done pulse at cycle 51; iter_cnt=2.
REQ-037 Write timing: each rd_en cycle with stage s and group g -> wr_en exactly 2 cycles later with identical tags; stage order 0,1,2,2,1,0.
REQ-038 Stall: hold=1 for 3 cycles at cycle 6 -> rd_en=wr_en=cell_en=0 during the hold; done moves to cycle 54; sequence otherwise unchanged.
REQ-039 Early stop: converged=1 at cycle 25 -> with BP_EARLY_STOP_EN, done at cycle 26 and iter_cnt=1; without the macro, done at cycle 51.
REQ-040 Reset and ignored start: rst_n=0 at cycle 10 -> all outputs 0 at cycle 11 and no done pulse; start pulsed while busy -> no effect.
